// File: rtl/hazard_pkg.sv
// hazard_pkg: forward-select encodings and stall FSM states shared by the hazard unit
package hazard_pkg;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  typedef enum logic {RUN, LSTALL} state_t;
endpackage

// File: rtl/fwd_sel.sv
// fwd_sel: priority forward mux for one ALU operand; Memory beats Writeback, x0 never forwards
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] rs_i,
  input  logic [ADDR_W-1:0] rd_m_i,
  input  logic [ADDR_W-1:0] rd_w_i,
  input  logic              we_m_i,
  input  logic              we_w_i,
  output logic [1:0]        sel_o
);
  always_comb
    sel_o = (we_m_i && rd_m_i != '0 && rd_m_i == rs_i) ? FWD_MEM :
            (we_w_i && rd_w_i != '0 && rd_w_i == rs_i) ? FWD_WB : FWD_REG;
endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: EX forwarding, load-use / RAW stall sequencing, branch flush and saturating perf counters
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int LOAD_LAT = 1,
  parameter int FWD_EN   = 1,
  parameter int PERF_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] RS1D,
  input  logic [ADDR_W-1:0] RS2D,
  input  logic [ADDR_W-1:0] RS1E,
  input  logic [ADDR_W-1:0] RS2E,
  input  logic [ADDR_W-1:0] RDE,
  input  logic [ADDR_W-1:0] RDM,
  input  logic [ADDR_W-1:0] RDW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              LoadE,
  input  logic              PCSrcE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
);
  // the first stall cycle is spent in RUN, so LSTALL covers the remaining LOAD_LAT-1
  localparam logic [2:0] CNT_INIT = LOAD_LAT > 1 ? 3'(LOAD_LAT - 2) : 3'd0;
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [PERF_W-1:0] stall_q, flush_q;
  logic [1:0] fwd_a, fwd_b;
  logic lu_hit, raw_hit, stall, flush;
  fwd_sel #(.ADDR_W(ADDR_W)) u_fwd_a (
    .rs_i(RS1E), .rd_m_i(RDM), .rd_w_i(RDW), .we_m_i(RegWriteM), .we_w_i(RegWriteW), .sel_o(fwd_a)
  );
  fwd_sel #(.ADDR_W(ADDR_W)) u_fwd_b (
    .rs_i(RS2E), .rd_m_i(RDM), .rd_w_i(RDW), .we_m_i(RegWriteM), .we_w_i(RegWriteW), .sel_o(fwd_b)
  );
  always_comb begin
    lu_hit = LoadE && RegWriteE && RDE != '0 && (RDE == RS1D || RDE == RS2D);
    raw_hit = FWD_EN == 0 &&
      ((RS1D != '0 && ((RegWriteE && RS1D == RDE) || (RegWriteM && RS1D == RDM))) ||
       (RS2D != '0 && ((RegWriteE && RS2D == RDE) || (RegWriteM && RS2D == RDM))));
    flush = state_q == RUN && PCSrcE;
    stall = state_q == LSTALL || (!PCSrcE && (lu_hit || raw_hit));
    state_d = state_q;
    cnt_d = cnt_q;
    if (state_q == LSTALL) begin
      state_d = cnt_q == '0 ? RUN : LSTALL;
      cnt_d = cnt_q == '0 ? cnt_q : cnt_q - 3'd1;
    end else if (stall && LOAD_LAT > 1) begin
      state_d = LSTALL;
      cnt_d = CNT_INIT;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      stall_q <= stall_q + PERF_W'(stall && !(&stall_q));
      flush_q <= flush_q + PERF_W'(flush && !(&flush_q));
    end
  end
  assign StallF = rst && stall;
  assign StallD = rst && stall;
  assign FlushD = rst && flush;
  assign FlushE = rst && (stall || flush);
  assign ForwardAE = (rst && FWD_EN != 0) ? fwd_a : FWD_REG;
  assign ForwardBE = (rst && FWD_EN != 0) ? fwd_b : FWD_REG;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: directed checks on three configurations (default, LOAD_LAT=3, PERF_W=2 with FWD_EN=0)
module tb_hazard_ctrl_unit;
  import hazard_pkg::*;
  logic clk = 1'b0, rst = 1'b0;
  logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic we_e, we_m, we_w, load_e, pcsrc_e;
  logic [3:0] l1_ctl, l3_ctl, p2_ctl;
  logic [1:0] l1_fa, l1_fb, l3_fa, l3_fb, p2_fa, p2_fb;
  logic [15:0] l1_sc, l1_fc, l3_sc, l3_fc;
  logic [1:0] p2_sc, p2_fc;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  hazard_ctrl_unit u_l1 (
    .clk(clk), .rst(rst), .RS1D(rs1d), .RS2D(rs2d), .RS1E(rs1e), .RS2E(rs2e), .RDE(rde), .RDM(rdm), .RDW(rdw),
    .RegWriteE(we_e), .RegWriteM(we_m), .RegWriteW(we_w), .LoadE(load_e), .PCSrcE(pcsrc_e),
    .StallF(l1_ctl[3]), .StallD(l1_ctl[2]), .FlushD(l1_ctl[1]), .FlushE(l1_ctl[0]),
    .ForwardAE(l1_fa), .ForwardBE(l1_fb), .stall_cnt(l1_sc), .flush_cnt(l1_fc)
  );
  hazard_ctrl_unit #(.LOAD_LAT(3)) u_l3 (
    .clk(clk), .rst(rst), .RS1D(rs1d), .RS2D(rs2d), .RS1E(rs1e), .RS2E(rs2e), .RDE(rde), .RDM(rdm), .RDW(rdw),
    .RegWriteE(we_e), .RegWriteM(we_m), .RegWriteW(we_w), .LoadE(load_e), .PCSrcE(pcsrc_e),
    .StallF(l3_ctl[3]), .StallD(l3_ctl[2]), .FlushD(l3_ctl[1]), .FlushE(l3_ctl[0]),
    .ForwardAE(l3_fa), .ForwardBE(l3_fb), .stall_cnt(l3_sc), .flush_cnt(l3_fc)
  );
  hazard_ctrl_unit #(.PERF_W(2), .FWD_EN(0)) u_p2 (
    .clk(clk), .rst(rst), .RS1D(rs1d), .RS2D(rs2d), .RS1E(rs1e), .RS2E(rs2e), .RDE(rde), .RDM(rdm), .RDW(rdw),
    .RegWriteE(we_e), .RegWriteM(we_m), .RegWriteW(we_w), .LoadE(load_e), .PCSrcE(pcsrc_e),
    .StallF(p2_ctl[3]), .StallD(p2_ctl[2]), .FlushD(p2_ctl[1]), .FlushE(p2_ctl[0]),
    .ForwardAE(p2_fa), .ForwardBE(p2_fb), .stall_cnt(p2_sc), .flush_cnt(p2_fc)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic clr;
    {rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw} = '0;
    {we_e, we_m, we_w, load_e, pcsrc_e} = '0;
  endtask
  task automatic load_hazard;
    load_e = 1'b1;
    we_e = 1'b1;
    rde = 5'd5;
    rs2d = 5'd5;
  endtask
  task automatic test_reset;
    clr();
    #3;
    total++;
    if ({l1_ctl, l3_ctl, p2_ctl} !== 12'h000) begin bad++; $display("FAIL reset_ctl got=%h exp=000", {l1_ctl, l3_ctl, p2_ctl}); end
    total++;
    if ({l1_sc, l1_fc, l3_sc, p2_sc} !== '0) begin bad++; $display("FAIL reset_cnt got=%h exp=0", {l1_sc, l1_fc, l3_sc, p2_sc}); end
    step();
    rst = 1'b1;
  endtask
  task automatic test_forward;
    rs1e = 5'd1; rdm = 5'd1; we_m = 1'b1;
    rs2e = 5'd2; rdw = 5'd2; we_w = 1'b1;
    #1;
    total++;
    if ({l1_fa, l1_fb} !== 4'b1001) begin bad++; $display("FAIL fwd_mw got=%b exp=1001", {l1_fa, l1_fb}); end
    total++;
    if ({p2_fa, p2_fb} !== 4'b0000) begin bad++; $display("FAIL fwd_disabled got=%b exp=0000", {p2_fa, p2_fb}); end
    rs1e = 5'd0; rs2e = 5'd0;
    #1;
    total++;
    if ({l1_fa, l1_fb} !== 4'b0000) begin bad++; $display("FAIL fwd_x0 got=%b exp=0000", {l1_fa, l1_fb}); end
    total++;
    if ({l1_ctl, p2_ctl} !== 8'h00) begin bad++; $display("FAIL fwd_no_stall got=%h exp=00", {l1_ctl, p2_ctl}); end
    clr();
  endtask
  task automatic test_priority;
    rdm = 5'd1; rdw = 5'd1; we_m = 1'b1; we_w = 1'b1; rs1e = 5'd1; rs2e = 5'd1;
    #1;
    total++;
    if ({l1_fa, l1_fb} !== 4'b1010) begin bad++; $display("FAIL fwd_m_prio got=%b exp=1010", {l1_fa, l1_fb}); end
    we_m = 1'b0;
    #1;
    total++;
    if (l1_fa !== 2'b01) begin bad++; $display("FAIL fwd_w_only got=%b exp=01", l1_fa); end
    clr();
  endtask
  task automatic test_load_use;
    step();
    load_hazard();
    #1;
    total++;
    if (l1_ctl !== 4'b1101) begin bad++; $display("FAIL lu_l1_ctl got=%b exp=1101", l1_ctl); end
    total++;
    if (l3_ctl !== 4'b1101) begin bad++; $display("FAIL lu_l3_ctl got=%b exp=1101", l3_ctl); end
    step();
    clr();
    #1;
    total++;
    if (l1_ctl !== 4'b0000 || l1_sc !== 16'd1) begin bad++; $display("FAIL lu_l1_after got=%b/%0d exp=0000/1", l1_ctl, l1_sc); end
    total++;
    if (l3_ctl !== 4'b1101 || u_l3.state_q !== LSTALL) begin bad++; $display("FAIL lu_l3_c2 got=%b/%0d exp=1101/1", l3_ctl, u_l3.state_q); end
    step();
    total++;
    if (l3_ctl !== 4'b1101 || u_l3.state_q !== LSTALL) begin bad++; $display("FAIL lu_l3_c3 got=%b/%0d exp=1101/1", l3_ctl, u_l3.state_q); end
    step();
    total++;
    if (l3_ctl !== 4'b0000 || u_l3.state_q !== RUN || l3_sc !== 16'd3) begin bad++; $display("FAIL lu_l3_done got=%b/%0d/%0d exp=0000/0/3", l3_ctl, u_l3.state_q, l3_sc); end
    total++;
    if (p2_sc !== 2'd1) begin bad++; $display("FAIL lu_p2_cnt got=%0d exp=1", p2_sc); end
  endtask
  task automatic test_branch;
    load_hazard();
    pcsrc_e = 1'b1;
    #1;
    total++;
    if (l1_ctl !== 4'b0011) begin bad++; $display("FAIL br_prio got=%b exp=0011", l1_ctl); end
    step();
    clr();
    #1;
    total++;
    if (l1_fc !== 16'd1 || l1_sc !== 16'd1 || l3_ctl !== 4'b0000) begin bad++; $display("FAIL br_cnt got=%0d/%0d/%b exp=1/1/0000", l1_fc, l1_sc, l3_ctl); end
    pcsrc_e = 1'b1;
    repeat (4) step();
    clr();
    #1;
    total++;
    if (p2_fc !== 2'd3) begin bad++; $display("FAIL br_sat got=%0d exp=3", p2_fc); end
    total++;
    if (l1_fc !== 16'd5) begin bad++; $display("FAIL br_five got=%0d exp=5", l1_fc); end
  endtask
  task automatic test_raw_stall;
    rs1d = 5'd7; rdm = 5'd7; we_m = 1'b1;
    #1;
    total++;
    if (p2_ctl !== 4'b1101 || l1_ctl !== 4'b0000) begin bad++; $display("FAIL raw_hit got=%b/%b exp=1101/0000", p2_ctl, l1_ctl); end
    step();
    clr();
    rs1d = 5'd0; rde = 5'd0; we_e = 1'b1;
    #1;
    total++;
    if (p2_ctl !== 4'b0000 || p2_sc !== 2'd2) begin bad++; $display("FAIL raw_x0 got=%b/%0d exp=0000/2", p2_ctl, p2_sc); end
    clr();
  endtask
  task automatic test_reset_mid;
    step();
    load_hazard();
    step();
    clr();
    rs1e = 5'd1; rdm = 5'd1; we_m = 1'b1;
    #1;
    total++;
    if (l3_ctl !== 4'b1101 || l3_fa !== 2'b10) begin bad++; $display("FAIL mid_pre got=%b/%b exp=1101/10", l3_ctl, l3_fa); end
    rst = 1'b0;
    #1;
    total++;
    if (l3_ctl !== 4'b0000 || l3_fa !== 2'b00 || l3_sc !== 16'd0 || u_l3.state_q !== RUN) begin bad++; $display("FAIL mid_rst got=%b/%b/%0d/%0d exp=0000/00/0/0", l3_ctl, l3_fa, l3_sc, u_l3.state_q); end
    step();
    rst = 1'b1;
    #1;
    total++;
    if (l3_ctl !== 4'b0000 || u_l3.state_q !== RUN || l3_sc !== 16'd0 || l3_fa !== 2'b10) begin bad++; $display("FAIL mid_release got=%b/%0d/%0d/%b exp=0000/0/0/10", l3_ctl, u_l3.state_q, l3_sc, l3_fa); end
    step();
    total++;
    if (l3_ctl !== 4'b0000 || l3_sc !== 16'd0) begin bad++; $display("FAIL mid_stays got=%b/%0d exp=0000/0", l3_ctl, l3_sc); end
  endtask
  initial begin
    test_reset();
    test_forward();
    test_priority();
    test_load_use();
    test_branch();
    test_raw_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
